// File: rtl/pixel_stream_reader.sv
// Frame read-out engine: walks the frame buffer in raster order, colour-maps
// iteration counts and streams pixels through a 2-entry ready/valid buffer.
module pixel_stream_reader #(
   parameter int IMG_W    = 160,
   parameter int IMG_H    = 120,
   parameter int MAX_ITER = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        rd_en,
   output logic [14:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_rgb,
   output logic        out_sof,
   output logic        out_eol,
   output logic        out_eof,
   output logic        done
);

   localparam logic [14:0] LAST  = 15'(IMG_W * IMG_H - 1);
   localparam logic [14:0] XLAST = 15'(IMG_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state, state_nx;
   logic [14:0] ptr, x;
   logic        inf_vld, inf_sof, inf_eol, inf_eof;
   logic [14:0] fifo [2];
   logic        wp, rp;
   logic [1:0]  cnt;
   logic        push, pop;
   logic [2:0]  occ;
   logic [11:0] rgb_in;

   assign push      = inf_vld;
   assign out_valid = (cnt != 2'd0);
   assign pop       = out_valid && out_ready;
   assign rd_addr   = ptr;
   assign {out_sof, out_eol, out_eof, out_rgb} = fifo[rp];

   // Occupancy after this cycle's pop; counting the pop keeps one beat per clock.
   assign occ    = {1'b0, cnt} + {2'b00, inf_vld} - {2'b00, pop};
   assign rgb_in = (rd_data == 8'(MAX_ITER)) ? '0 : {4'hF, rd_data[7:4], 4'h0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (rd_en && ptr == LAST) state_nx = DRAIN;
         DRAIN:   if (pop && out_eof) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      rd_en = (state == RUN) && (occ < 3'd2);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr     <= '0;
         x       <= '0;
         inf_vld <= 1'b0;
         inf_sof <= 1'b0;
         inf_eol <= 1'b0;
         inf_eof <= 1'b0;
         fifo[0] <= '0;
         fifo[1] <= '0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         cnt     <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == DRAIN) && pop && out_eof;
         if (state == IDLE && start) begin
            ptr <= '0;
            x   <= '0;
         end else if (rd_en) begin
            if (ptr != LAST) ptr <= ptr + 15'd1;
            x <= (x == XLAST) ? '0 : x + 15'd1;
         end
         // Flags travel with the read so the beat carries its own position.
         inf_vld <= rd_en;
         inf_sof <= (ptr == '0);
         inf_eol <= (x == XLAST);
         inf_eof <= (ptr == LAST);
         if (push) begin
            fifo[wp] <= {inf_sof, inf_eol, inf_eof, rgb_in};
            wp       <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

endmodule
